// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: shares a single-port RAM between display prefetch (pixel FIFO) and CPU writes.
// Optional build macro VGA_FB_UNDERFLOW_COLOR_EN: underflow pixels show magenta instead of black.
module vga_fb_arbiter #(
   parameter int unsigned H_RES      = 640,
   parameter int unsigned V_RES      = 480,
   parameter int unsigned AW         = 19,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned LOW_WATER  = 4
) (
   input  logic          pclk,
   input  logic          reset,
   input  logic          vsync,
   input  logic          valid,
   output logic [23:0]   vga_data,
   input  logic          cpu_wr_valid,
   output logic          cpu_wr_ready,
   input  logic [AW-1:0] cpu_wr_addr,
   input  logic [23:0]   cpu_wr_data,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [23:0]   mem_wdata,
   input  logic [23:0]   mem_rdata,
   output logic          underflow
);

   localparam int unsigned DW   = 24;
   localparam int unsigned NPIX = H_RES * V_RES;
   localparam int unsigned PW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CW   = PW + 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
`ifdef VGA_FB_UNDERFLOW_COLOR_EN
   localparam logic [DW-1:0] UF_COLOR = 24'hFF00FF;
`else
   localparam logic [DW-1:0] UF_COLOR = 24'h000000;
`endif

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_e;

   state_e            state_q, state_d;
   logic              vsync_q;
   logic [AW-1:0]     fetch_addr_q, fetch_addr_d;
   logic              inflight_q, inflight_d;
   logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              underflow_q, underflow_d;
   logic [DW-1:0]     fifo_q [FIFO_DEPTH];

   logic              frame_start, fifo_empty, eligible, urgent;
   logic              grant_fetch, grant_cpu, push, pop;
   logic [CW-1:0]     occ;

   // Occupancy counts the read in flight so the FIFO can never be over-committed
   assign frame_start = vsync_q & ~vsync;
   assign occ         = count_q + CW'(inflight_q);
   assign fifo_empty  = (count_q == '0);
   assign eligible    = ~reset & ~frame_start & (state_q == S_FETCH) & (occ < CW'(FIFO_DEPTH));
   assign urgent      = eligible & (occ < CW'(LOW_WATER));
   assign push        = inflight_q;
   assign pop         = valid & ~fifo_empty;

   always_ff @(posedge pclk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (frame_start)
         state_d = S_FETCH;
      else if (grant_fetch && (fetch_addr_q == LAST_ADDR))
         state_d = S_DONE;
   end

   // Grant decode and RAM port drive
   always_comb begin
      grant_fetch  = 1'b0;
      grant_cpu    = 1'b0;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      if (urgent)                    grant_fetch = 1'b1;
      else if (cpu_wr_valid && !reset) grant_cpu = 1'b1;
      else if (eligible)             grant_fetch = 1'b1;
      if (grant_cpu) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = cpu_wr_addr;
         mem_wdata = cpu_wr_data;
      end else if (grant_fetch) begin
         mem_en    = 1'b1;
         mem_addr  = fetch_addr_q;
      end
      cpu_wr_ready = grant_cpu;
   end

   // Frame start flushes everything, including a read returning this cycle
   always_comb begin
      fetch_addr_d = fetch_addr_q;
      inflight_d   = inflight_q;
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      count_d      = count_q;
      underflow_d  = underflow_q;
      if (frame_start) begin
         fetch_addr_d = '0;
         inflight_d   = 1'b0;
         wptr_d       = '0;
         rptr_d       = '0;
         count_d      = '0;
         underflow_d  = 1'b0;
      end else begin
         fetch_addr_d = fetch_addr_q + AW'(grant_fetch);
         inflight_d   = grant_fetch;
         if (push) wptr_d = wptr_q + PW'(1);
         if (pop)  rptr_d = rptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
         if (valid && fifo_empty) underflow_d = 1'b1;
      end
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         vsync_q      <= 1'b1;
         fetch_addr_q <= '0;
         inflight_q   <= 1'b0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
         underflow_q  <= 1'b0;
      end else begin
         vsync_q      <= vsync;
         fetch_addr_q <= fetch_addr_d;
         inflight_q   <= inflight_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         count_q      <= count_d;
         underflow_q  <= underflow_d;
      end
   end

   always_ff @(posedge pclk) begin
      if (push && !frame_start) fifo_q[wptr_q] <= mem_rdata;
   end

   always_comb begin
      vga_data = '0;
      if (!reset && valid) vga_data = fifo_empty ? UF_COLOR : fifo_q[rptr_q];
   end

   assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized bench for vga_fb_arbiter against a queue-based reference model of the arbitration rules.
module tb_vga_fb_arbiter;

   localparam int unsigned H = 16, V = 4, AW = 8, DEPTH = 8, LW = 4;
   localparam int unsigned NPIX = H * V;
   localparam int unsigned OW = 4 + AW + 48;
`ifdef VGA_FB_UNDERFLOW_COLOR_EN
   localparam logic [23:0] UF = 24'hFF00FF;
`else
   localparam logic [23:0] UF = 24'h000000;
`endif

   logic pclk = 1'b0;
   logic reset, vsync, valid, cpu_wr_valid, cpu_wr_ready;
   logic [AW-1:0] cpu_wr_addr, mem_addr;
   logic [23:0] cpu_wr_data, vga_data, mem_wdata;
   logic [23:0] mem_rdata = '0;
   logic mem_en, mem_we, underflow;
   logic [23:0] ram [0:255];

   int total = 0, bad = 0;

   vga_fb_arbiter #(.H_RES(H), .V_RES(V), .AW(AW), .FIFO_DEPTH(DEPTH), .LOW_WATER(LW)) dut (
      .pclk(pclk), .reset(reset), .vsync(vsync), .valid(valid), .vga_data(vga_data),
      .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready), .cpu_wr_addr(cpu_wr_addr),
      .cpu_wr_data(cpu_wr_data), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .underflow(underflow)
   );

   always #5 pclk = ~pclk;

   // Single-port RAM with one cycle read latency
   always @(posedge pclk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   // Reference model state
   int          m_state;          // 0 idle, 1 fetching, 2 done
   logic [23:0] m_fifo [$];
   bit          m_inflight, m_uf, m_vsq;
   logic [23:0] m_idata;
   int          m_faddr, m_occ;
   bit          m_fs, m_gfetch, m_gcpu;
   logic [23:0] sh_mem [0:255];
   logic [OW-1:0] m_exp;

   function automatic logic [OW-1:0] obs();
      return {mem_en, mem_we, mem_addr, mem_wdata, cpu_wr_ready, vga_data, underflow};
   endfunction

   task automatic model_eval();
      bit elig, urg;
      logic [AW-1:0] ea;
      logic [23:0] ew, ev;
      m_fs   = !reset && m_vsq && !vsync;
      m_occ  = m_fifo.size() + (m_inflight ? 1 : 0);
      elig   = !reset && !m_fs && (m_state == 1) && (m_occ < DEPTH);
      urg    = elig && (m_occ < LW);
      m_gfetch = urg || (elig && !cpu_wr_valid);
      m_gcpu   = !reset && !urg && cpu_wr_valid;
      ea = m_gcpu ? cpu_wr_addr : (m_gfetch ? AW'(m_faddr) : '0);
      ew = m_gcpu ? cpu_wr_data : '0;
      if (reset || !valid)        ev = '0;
      else if (m_fifo.size() == 0) ev = UF;
      else                        ev = m_fifo[0];
      m_exp = {m_gcpu || m_gfetch, m_gcpu, ea, ew, m_gcpu, ev, m_uf};
   endtask

   task automatic model_tick();
      if (reset) begin
         m_state = 0; m_fifo.delete(); m_inflight = 0; m_faddr = 0; m_uf = 0; m_vsq = 1;
         return;
      end
      if (m_gcpu) sh_mem[cpu_wr_addr] = cpu_wr_data;
      if (m_fs) begin
         m_fifo.delete(); m_inflight = 0; m_faddr = 0; m_uf = 0; m_state = 1;
      end else begin
         if (valid) begin
            if (m_fifo.size() > 0) void'(m_fifo.pop_front());
            else m_uf = 1;
         end
         if (m_inflight) m_fifo.push_back(m_idata);
         m_inflight = m_gfetch;
         if (m_gfetch) begin
            m_idata = sh_mem[m_faddr];
            if (m_faddr == NPIX - 1) m_state = 2;
            m_faddr++;
         end
      end
      m_vsq = vsync;
   endtask

   task automatic settle();
      #1;
      model_eval();
   endtask

   task automatic step();
      @(posedge pclk);
      model_tick();
      @(negedge pclk);
   endtask

   task automatic test_reset();
      reset = 1; vsync = 1; valid = 0; cpu_wr_valid = 0; cpu_wr_addr = '0; cpu_wr_data = '0;
      settle(); step(); settle(); step();
      settle();
      total++;
      if (obs() !== '0) begin bad++; $display("FAIL reset_init got=%h exp=0", obs()); end
      reset = 0; settle(); step();
      vsync = 0;
      for (int i = 0; i < 4; i++) begin
         settle();
         total++;
         if (obs() !== m_exp) begin bad++; $display("FAIL reset_prefetch i=%0d got=%h exp=%h", i, obs(), m_exp); end
         step();
      end
      reset = 1; vsync = 1;
      for (int i = 0; i < 3; i++) begin
         settle();
         total++;
         if (obs() !== '0) begin bad++; $display("FAIL reset_hold i=%0d got=%h exp=0", i, obs()); end
         step();
      end
      reset = 0;
      for (int i = 0; i < 6; i++) begin
         valid = (i >= 4);
         settle();
         total++;
         if (mem_en !== 1'b0 || obs() !== m_exp) begin
            bad++; $display("FAIL reset_after i=%0d got=%h exp=%h", i, obs(), m_exp);
         end
         step();
      end
      valid = 0;
   endtask

   task automatic test_prefill();
      vsync = 0;
      settle();
      total++;
      if (obs() !== m_exp) begin bad++; $display("FAIL prefill_fs got=%h exp=%h", obs(), m_exp); end
      step();
      for (int i = 0; i < 12; i++) begin
         settle();
         total++;
         if ((i < 8 && (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(i))) ||
             (i >= 8 && mem_en !== 1'b0) || obs() !== m_exp) begin
            bad++; $display("FAIL prefill_read i=%0d got=%h exp=%h", i, obs(), m_exp);
         end
         step();
      end
      valid = 1;
      for (int k = 0; k < NPIX; k++) begin
         settle();
         total++;
         if (vga_data !== 24'(k) || underflow !== 1'b0 || obs() !== m_exp) begin
            bad++; $display("FAIL prefill_pixel k=%0d got=%h exp_pix=%h exp=%h", k, vga_data, 24'(k), m_exp);
         end
         step();
      end
      valid = 0; vsync = 1;
      settle(); step();
   endtask

   task automatic test_cpu_priority();
      vsync = 0; cpu_wr_valid = 1;
      for (int i = 0; i < 16; i++) begin
         cpu_wr_addr = AW'($urandom_range(0, NPIX + 15));
         cpu_wr_data = 24'($urandom);
         settle();
         total++;
         if ((i > 0 && cpu_wr_ready !== (m_occ >= LW)) || obs() !== m_exp) begin
            bad++; $display("FAIL cpu_prio i=%0d occ=%0d got=%h exp=%h", i, m_occ, obs(), m_exp);
         end
         step();
      end
      for (int i = 0; i < 400; i++) begin
         vsync        = ($urandom_range(0, 99) < 3);
         valid        = ($urandom_range(0, 3) != 0);
         cpu_wr_valid = $urandom_range(0, 1);
         cpu_wr_addr  = AW'($urandom_range(0, NPIX + 15));
         cpu_wr_data  = 24'($urandom);
         settle();
         total++;
         if (obs() !== m_exp) begin bad++; $display("FAIL random i=%0d got=%h exp=%h", i, obs(), m_exp); end
         step();
      end
      vsync = 1; valid = 0; cpu_wr_valid = 0;
      settle(); step();
   endtask

   task automatic test_underflow();
      vsync = 0;
      settle(); step();
      valid = 1;
      settle();
      total++;
      if (vga_data !== UF || obs() !== m_exp) begin
         bad++; $display("FAIL uf_colour got=%h exp=%h", vga_data, UF);
      end
      step();
      valid = 0;
      settle();
      total++;
      if (underflow !== 1'b1 || obs() !== m_exp) begin bad++; $display("FAIL uf_flag got=%b exp=1", underflow); end
      step();
      vsync = 1; settle(); step();
      vsync = 0; settle(); step();
      settle();
      total++;
      if (underflow !== 1'b0 || obs() !== m_exp) begin bad++; $display("FAIL uf_clear got=%b exp=0", underflow); end
      step();
      vsync = 1;
   endtask

   task automatic test_done();
      int n;
      vsync = 0;
      n = 0;
      while (m_state != 2 && n < 1000) begin
         valid        = ($urandom_range(0, 3) != 0);
         cpu_wr_valid = ($urandom_range(0, 3) == 0);
         cpu_wr_addr  = AW'($urandom_range(0, NPIX + 15));
         cpu_wr_data  = 24'($urandom);
         settle();
         total++;
         if (obs() !== m_exp) begin bad++; $display("FAIL done_run n=%0d got=%h exp=%h", n, obs(), m_exp); end
         step();
         n++;
      end
      total++;
      if (m_state != 2) begin bad++; $display("FAIL done_timeout cycles=%0d exp_state=2", n); end
      valid = 0; cpu_wr_valid = 1;
      for (int i = 0; i < 12; i++) begin
         cpu_wr_addr = AW'($urandom_range(0, NPIX - 1));
         cpu_wr_data = 24'($urandom);
         settle();
         total++;
         if (cpu_wr_ready !== 1'b1 || mem_we !== 1'b1 || obs() !== m_exp) begin
            bad++; $display("FAIL done_cpu i=%0d got=%h exp=%h", i, obs(), m_exp);
         end
         step();
      end
      cpu_wr_valid = 0; vsync = 1;
      settle(); step();
   endtask

   task automatic test_flush();
      bit hit;
      vsync = 0; settle(); step();
      vsync = 1;
      hit = 0;
      for (int n = 0; n < 30; n++) begin
         if (m_fifo.size() == 5 && m_inflight) begin hit = 1; break; end
         settle();
         total++;
         if (obs() !== m_exp) begin bad++; $display("FAIL flush_fill n=%0d got=%h exp=%h", n, obs(), m_exp); end
         step();
      end
      total++;
      if (!hit) begin bad++; $display("FAIL flush_setup got=0 exp=1"); end
      vsync = 0;
      settle();
      total++;
      if (obs() !== m_exp) begin bad++; $display("FAIL flush_fs got=%h exp=%h", obs(), m_exp); end
      step();
      valid = 1;
      settle();
      total++;
      if (vga_data !== UF || mem_en !== 1'b1 || mem_addr !== '0 || obs() !== m_exp) begin
         bad++; $display("FAIL flush_after got=%h exp=%h", obs(), m_exp);
      end
      step();
      for (int i = 0; i < 18; i++) begin
         valid = (i >= 10);
         settle();
         total++;
         if (obs() !== m_exp) begin bad++; $display("FAIL flush_refill i=%0d got=%h exp=%h", i, obs(), m_exp); end
         step();
      end
      valid = 0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i]    = 24'(i);
         sh_mem[i] = 24'(i);
      end
      m_state = 0; m_inflight = 0; m_uf = 0; m_vsq = 1; m_faddr = 0; m_idata = '0;
      m_fs = 0; m_gfetch = 0; m_gcpu = 0; m_occ = 0; m_exp = '0;
      @(negedge pclk);
      test_reset();
      test_prefill();
      test_cpu_priority();
      test_underflow();
      test_done();
      test_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
